keypad_scanner: RTL and testbench

- Scans a 2-column × 4-row keypad matrix by driving one column low at a time.
- Samples the row lines through a synchroniser and reduces each complete scan frame to a 5-bit key word, `information`.
- `information` holds constant between frame boundaries. It feeds the key debouncer directly, so each frame gives the debouncer one stable sample.

---
 rtl/keypad_scanner.sv | 99 +++++++++
 tb/tb_keypad_scanner.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 2x4 keypad scanner: one 5-bit key word per frame, 2*(SETTLE_CYCLES+2)+1 cycles long, with no backpressure.
// Define KEYPAD_MULTI_KEY_EN to report multi-key frames as {1,1,lowest index}; otherwise they are rejected as 5'b0.
module keypad_scanner #(
  parameter int SETTLE_CYCLES = 3
) (
  input  logic       newClock,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [1:0] colDrive,
  output logic [4:0] information,
  output logic       frameDone
);

  typedef enum logic [1:0] {DRIVE, SETTLE, SAMPLE, PUBLISH} state_t;

  state_t     state;
  logic       col;
  logic [7:0] settle_cnt;
  logic [7:0] frame_acc;
  logic [3:0] rows_meta;
  logic [3:0] rows_sync;

  always_ff @(posedge newClock or posedge reset) begin
    if (reset) begin
      rows_meta <= 4'h0;
      rows_sync <= 4'h0;
    end else begin
      rows_meta <= rows;
      rows_sync <= rows_meta;
    end
  end

  // Scanning from the top index down leaves the lowest pressed index in idx.
  function automatic logic [4:0] reduce_frame(input logic [7:0] acc);
    logic       found;
    logic       multi;
    logic [2:0] idx;
    found = 1'b0;
    multi = 1'b0;
    idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (acc[i]) begin
        if (found) multi = 1'b1;
        found = 1'b1;
        idx   = 3'(i);
      end
    end
`ifdef KEYPAD_MULTI_KEY_EN
    return {found, multi, idx};
`else
    return (found && !multi) ? {2'b10, idx} : 5'b00000;
`endif
  endfunction

  always_ff @(posedge newClock or posedge reset) begin
    if (reset) begin
      state       <= DRIVE;
      col         <= 1'b0;
      settle_cnt  <= 8'd0;
      frame_acc   <= 8'd0;
      colDrive    <= 2'b11;
      information <= 5'b00000;
      frameDone   <= 1'b0;
    end else begin
      frameDone <= 1'b0;
      case (state)
        DRIVE: begin
          colDrive   <= col ? 2'b01 : 2'b10;
          settle_cnt <= 8'(SETTLE_CYCLES - 1);
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == 8'd0) state <= SAMPLE;
          else settle_cnt <= settle_cnt - 8'd1;
        end
        SAMPLE: begin
          if (col) begin
            frame_acc[7:4] <= ~rows_sync;
            state          <= PUBLISH;
          end else begin
            frame_acc[3:0] <= ~rows_sync;
            col            <= 1'b1;
            state          <= DRIVE;
          end
        end
        PUBLISH: begin
          colDrive    <= 2'b11;
          information <= reduce_frame(frame_acc);
          frameDone   <= 1'b1;
          frame_acc   <= 8'd0;
          col         <= 1'b0;
          state       <= DRIVE;
        end
        default: state <= DRIVE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized bench for keypad_scanner: keypad matrix model plus frame-level reference of the key word.
module tb_keypad_scanner;

  localparam int S  = 3;
  localparam int L  = 2 * (S + 2) + 1;
  localparam int S2 = 2;
  localparam int L2 = 2 * (S2 + 2) + 1;

  logic       newClock = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [1:0] colDrive;
  logic [4:0] information;
  logic       frameDone;
  logic [3:0] rows2;
  logic [1:0] colDrive2;
  logic [4:0] information2;
  logic       frameDone2;

  logic [7:0] keys;
  logic [7:0] frame_keys;
  logic [4:0] exp_info;
  int         n;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 newClock = ~newClock;

  keypad_scanner #(.SETTLE_CYCLES(S)) dut (
    .newClock(newClock), .reset(reset), .rows(rows),
    .colDrive(colDrive), .information(information), .frameDone(frameDone)
  );

  keypad_scanner #(.SETTLE_CYCLES(S2)) dut2 (
    .newClock(newClock), .reset(reset), .rows(rows2),
    .colDrive(colDrive2), .information(information2), .frameDone(frameDone2)
  );

  // Matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    rows = 4'hF;
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 4; r++)
        if (!colDrive[c] && keys[c*4+r]) rows[r] = 1'b0;
  end

  // Second scanner always sees key 0 held.
  always_comb rows2 = colDrive2[0] ? 4'hF : 4'hE;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, obs, expv);
    end
  endtask

  function automatic logic [4:0] ref_word(input logic [7:0] k);
    int cnt;
    int low;
    cnt = $countones(k);
    low = 0;
    for (int i = 7; i >= 0; i--) if (k[i]) low = i;
    if (cnt == 0) return 5'b00000;
    if (cnt == 1) return {2'b10, 3'(low)};
`ifdef KEYPAD_MULTI_KEY_EN
    return {2'b11, 3'(low)};
`else
    return 5'b00000;
`endif
  endfunction

  // One clock of both scanners, checked against the frame schedule.
  task automatic step();
    int         p;
    int         p2;
    logic [1:0] exp_cd;
    logic       exp_fd;
    if (n % L == 0) frame_keys = keys;
    @(posedge newClock);
    #1;
    n++;
    p = (n - 1) % L;
    if (p <= S + 1) exp_cd = 2'b10;
    else if (p <= 2 * S + 3) exp_cd = 2'b01;
    else exp_cd = 2'b11;
    exp_fd = (p == L - 1);
    if (exp_fd) exp_info = ref_word(frame_keys);
    check("col_drive", 8'(colDrive), 8'(exp_cd));
    check("frame_done", 8'(frameDone), 8'(exp_fd));
    check("information", 8'(information), 8'(exp_info));
    p2 = (n - 1) % L2;
    check("s2_frame_done", 8'(frameDone2), 8'(p2 == L2 - 1));
    check("s2_col_not_00", 8'(colDrive2 == 2'b00), 8'd0);
    check("s2_information", 8'(information2), (n >= L2) ? 8'h10 : 8'h00);
  endtask

  task automatic run_frame();
    repeat (L) step();
  endtask

  initial begin
    logic [4:0] two_exp;
    int         a;
    int         b;
    reset      = 1'b1;
    keys       = 8'h00;
    frame_keys = 8'h00;
    exp_info   = 5'b0;
    n          = 0;
    repeat (3) @(posedge newClock);
    #1;
    check("rst_col_drive", 8'(colDrive), 8'h03);
    check("rst_information", 8'(information), 8'h00);
    check("rst_frame_done", 8'(frameDone), 8'h00);
    check("rst_s2_col_drive", 8'(colDrive2), 8'h03);
    @(negedge newClock);
    reset = 1'b0;

    run_frame();
    run_frame();

    keys = 8'h40;
    run_frame();
    check("single_key6", 8'(information), 8'h16);
    keys = 8'h00;
    run_frame();
    check("single_release", 8'(information), 8'h00);

    keys = 8'h22;
    run_frame();
`ifdef KEYPAD_MULTI_KEY_EN
    two_exp = 5'b11001;
`else
    two_exp = 5'b00000;
`endif
    check("two_keys", 8'(information), 8'(two_exp));
    keys = 8'h00;
    run_frame();

    for (int f = 0; f < 100; f++) begin
      case ($urandom_range(0, 3))
        0: keys = 8'h00;
        1: keys = 8'h01 << $urandom_range(0, 7);
        2: begin
          a = $urandom_range(0, 7);
          b = (a + $urandom_range(1, 7)) % 8;
          keys = (8'h01 << a) | (8'h01 << b);
        end
        default: keys = 8'($urandom);
      endcase
      run_frame();
    end

    // Reset in the middle of column 1 settling with key 2 held.
    keys = 8'h04;
    repeat (S + 4) step();
    #3;
    reset = 1'b1;
    #1;
    check("midrst_col_drive", 8'(colDrive), 8'h03);
    check("midrst_information", 8'(information), 8'h00);
    check("midrst_frame_done", 8'(frameDone), 8'h00);
    repeat (2) @(posedge newClock);
    #1;
    check("midrst_hold_frame_done", 8'(frameDone), 8'h00);
    check("midrst_hold_col_drive", 8'(colDrive), 8'h03);
    @(negedge newClock);
    reset    = 1'b0;
    n        = 0;
    exp_info = 5'b0;
    run_frame();
    check("midrst_resume", 8'(information), 8'h12);
    run_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
